// File: rtl/mem_read_pkg.sv
// Shared types and helpers for the data-memory load port.
// Size encodings, response FIFO depth, side-pipeline record, lane formatting.
package mem_read_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int RSP_DEPTH = 2;

    // Travels alongside the RAM read for one cycle.
    typedef struct packed {
        logic       valid;
        logic [1:0] lane;
        logic [1:0] size;
        logic       sgn;
        logic       err;
    } side_t;

    function automatic logic align_err(
        input logic [1:0] lane,
        input logic [1:0] size
    );
        logic e;
        e = 1'b0;
        unique case (size)
            SIZE_BYTE: e = 1'b0;
            SIZE_HALF: e = lane[0];
            SIZE_WORD: e = (lane != 2'd0);
            default:   e = 1'b1;
        endcase
        return e;
    endfunction

    // Picks the addressed lane and extends it to a full word.
    function automatic logic [31:0] load_fmt(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[7:0];
        unique case (lane)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            2'd3: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        r = w;
        if (size == SIZE_BYTE) begin
            r = {{24{sgn & b[7]}}, b};
        end else if (size == SIZE_HALF) begin
            r = {{16{sgn & h[15]}}, h};
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_read_port_fifo.sv
// Two-entry response buffer holding {err, data}; head is zero when empty.
// Ports: clk, rst, clr, push/push_data, pop, occ, valid, head.
module resp_fifo
    import mem_read_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic         valid,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [RSP_DEPTH];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   occ_q, occ_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (clr) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            occ_d = 2'd0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            occ_q <= 2'd0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
            if (push && !clr) begin
                mem_q[wr_q] <= push_data;
            end
        end
    end

    assign occ   = occ_q;
    assign valid = (occ_q != 2'd0);
    assign head  = valid ? mem_q[rd_q] : '0;

endmodule

// File: rtl/mem_read_port.sv
// Load-side data-memory read port: request handshake, 1-cycle RAM, 2-entry response buffer.
// Ports: clk, rst, flush, req_* (valid/ready/addr[/size/signed]), mem_en/addr/rdata, rsp_* (valid/ready/data/err).
// MEM_READ_SUBWORD_EN adds req_size/req_signed and byte/half loads; otherwise every access is a word load.
module mem_read_port
    import mem_read_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
`ifdef MEM_READ_SUBWORD_EN
    input  logic [1:0]        req_size,
    input  logic              req_signed,
`endif
    output logic              mem_en,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    logic [1:0]  size_w;
    logic        sgn_w;
    side_t       side_q, side_d;
    logic [1:0]  occ;
    logic [2:0]  used;
    logic        accept;
    logic        pop;
    logic        push;
    logic [DATA_W:0] push_data;
    logic [DATA_W:0] head;

`ifdef MEM_READ_SUBWORD_EN
    assign size_w = req_size;
    assign sgn_w  = req_signed;
`else
    assign size_w = SIZE_WORD;
    assign sgn_w  = 1'b0;
`endif

    // Credits: buffered plus in-flight never exceeds the buffer depth;
    // a pop in the same cycle frees one slot for the new request.
    assign used      = {1'b0, occ} + {2'b00, side_q.valid};
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = !rst && !flush &&
                       ((used < 3'(RSP_DEPTH)) || pop);
    assign accept    = req_valid && req_ready;
    assign mem_en    = accept;
    assign mem_addr  = req_addr[ADDR_W-1:2];

    always_comb begin
        side_d       = '0;
        side_d.valid = accept;
        side_d.lane  = req_addr[1:0];
        side_d.size  = size_w;
        side_d.sgn   = sgn_w;
        side_d.err   = align_err(req_addr[1:0], size_w);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            side_q <= '0;
        end else begin
            side_q <= side_d;
        end
    end

    // Misaligned loads still read the RAM but push zero data.
    assign push      = side_q.valid && !flush;
    assign push_data = side_q.err ? {1'b1, {DATA_W{1'b0}}} :
                       {1'b0, load_fmt(mem_rdata, side_q.lane,
                                       side_q.size, side_q.sgn)};

    resp_fifo #(.W(DATA_W + 1)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .occ       (occ),
        .valid     (rsp_valid),
        .head      (head)
    );

    assign rsp_err  = head[DATA_W];
    assign rsp_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_mem_read_port.sv
// Directed self-checking bench for mem_read_port.
// Table of single loads plus hand-written backpressure, flush and reset sequences.
module tb_mem_read_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic [31:0] ram [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_read_port #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
`ifdef MEM_READ_SUBWORD_EN
        .req_size   (req_size),
        .req_signed (req_signed),
`endif
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= ram[mem_addr[3:0]];
    end

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] word;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_load(input vec_t v, input string nm);
        ram[v.addr[5:2]] = v.word;
        @(negedge clk);
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_size   = v.size;
        req_signed = v.sgn;
        #1;
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, " mem_en"}, 32'(mem_en), 32'd1);
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'(v.addr[31:2]));
        @(negedge clk);
        req_valid = 1'b0;
        chk({nm, " early valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, " rsp_data"}, rsp_data, v.exp);
        chk({nm, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        @(negedge clk);
        chk({nm, " drained"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int got;
        int first_cyc;
        int last_cyc;

        vecs.push_back('{32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{32'h20, 2'b10, 1'b0, 32'h12345678, 32'h12345678, 1'b0});
        vecs.push_back('{32'h3C, 2'b10, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{32'h13, 2'b10, 1'b0, 32'h55AA55AA, 32'h0, 1'b1});
        vecs.push_back('{32'h02, 2'b10, 1'b0, 32'h11111111, 32'h0, 1'b1});
        vecs.push_back('{32'h01, 2'b10, 1'b0, 32'h22222222, 32'h0, 1'b1});
`ifdef MEM_READ_SUBWORD_EN
        vecs.push_back('{32'h13, 2'b00, 1'b1, 32'h80FF0000, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{32'h13, 2'b00, 1'b0, 32'h80FF0000, 32'h00000080, 1'b0});
        vecs.push_back('{32'h12, 2'b01, 1'b0, 32'h80FF0000, 32'h000080FF, 1'b0});
        vecs.push_back('{32'h12, 2'b01, 1'b1, 32'h80FF0000, 32'hFFFF80FF, 1'b0});
        vecs.push_back('{32'h11, 2'b00, 1'b0, 32'h0000AB00, 32'h000000AB, 1'b0});
        vecs.push_back('{32'h11, 2'b01, 1'b0, 32'h0000AB00, 32'h0, 1'b1});
        vecs.push_back('{32'h10, 2'b11, 1'b0, 32'h0000AB00, 32'h0, 1'b1});
`endif

        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        mem_rdata  = 32'h0;
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        rsp_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("post-rst req_ready", 32'(req_ready), 32'd1);

        // Table of single loads
        foreach (vecs[i]) begin
            do_load(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back word loads at full throughput
        for (int i = 0; i < 8; i++) ram[i] = 32'hA0000000 + 32'(i);
        got = 0;
        first_cyc = -1;
        last_cyc = -1;
        req_size = 2'b10;
        req_signed = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            if (rsp_valid) begin
                chk("b2b data", rsp_data, 32'hA0000000 + 32'(got));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (cyc < 8) begin
                req_valid = 1'b1;
                req_addr  = 32'(cyc * 4);
                #1;
                chk("b2b req_ready", 32'(req_ready), 32'd1);
            end else begin
                req_valid = 1'b0;
            end
        end
        chk("b2b count", 32'(got), 32'd8);
        chk("b2b spacing", 32'(last_cyc - first_cyc), 32'd7);

        // Backpressure: two accepted, third held until a pop
        ram[0] = 32'hB0000000;
        ram[1] = 32'hB0000001;
        ram[2] = 32'hB0000002;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        #1;
        chk("bp r0 ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_addr = 32'h4;
        #1;
        chk("bp r1 ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_addr = 32'h8;
        #1;
        chk("bp r2 blocked", 32'(req_ready), 32'd0);
        chk("bp r2 mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        #1;
        chk("bp full ready", 32'(req_ready), 32'd0);
        chk("bp full valid", 32'(rsp_valid), 32'd1);
        chk("bp head", rsp_data, 32'hB0000000);
        @(negedge clk);
        chk("bp stable", rsp_data, 32'hB0000000);
        rsp_ready = 1'b1;
        #1;
        chk("bp pop ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp second", rsp_data, 32'hB0000001);
        chk("bp second valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("bp third", rsp_data, 32'hB0000002);
        chk("bp third valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("bp empty", 32'(rsp_valid), 32'd0);

        // Flush with one buffered and one in flight
        ram[3] = 32'hC0000003;
        ram[4] = 32'hBAD00004;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'hC;
        @(negedge clk);
        req_addr = 32'h10;
        @(negedge clk);
        chk("fl pre valid", 32'(rsp_valid), 32'd1);
        flush = 1'b1;
        req_addr = 32'h14;
        #1;
        chk("fl req_ready", 32'(req_ready), 32'd0);
        chk("fl mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("fl valid", 32'(rsp_valid), 32'd0);
        chk("fl ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("fl no ghost", 32'(rsp_valid), 32'd0);
        chk("fl data", rsp_data, 32'd0);

        // Reset in the middle of traffic
        ram[5] = 32'hD0000005;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h14;
        @(negedge clk);
        req_addr = 32'h14;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst req_ready", 32'(req_ready), 32'd0);
        chk("mrst mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst rsp_data", rsp_data, 32'd0);
        chk("mrst rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("mrst ready after", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("mrst no stale", 32'(rsp_valid), 32'd0);
        do_load('{32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0},
                "after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
